regfile_wport_arbiter: RTL and testbench

- Shares the single write port of the 2-read/1-write register file among NUM_REQ writeback sources, for example ALU writeback and load writeback.
- Arbitration is fixed priority (lowest index wins), with an aging override that bounds starvation.
- The granted write is registered once and then drives the regfile write port.
- The same register also serves as the bypass source for the write committing this cycle.

---
 rtl/regfile_wport_arbiter_pkg.sv | 16 +
 rtl/regfile_wport_arbiter_if.sv | 29 ++
 rtl/regfile_wport_arbiter_age.sv | 37 +++
 rtl/regfile_wport_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
// Optional statistics are enabled by defining REGFILE_WPORT_ARBITER_STATS_EN.
package regfile_wport_arbiter_pkg;

  localparam int unsigned StatsWidth   = 32;
  localparam int unsigned MaxWaitLimit = 15;

  function automatic int unsigned addr_width(input int unsigned size);
    return $clog2(size);
  endfunction

  // Wide enough for any legal MAX_WAIT (1..15).
  typedef logic [$clog2(MaxWaitLimit + 1)-1:0] age_t;
  typedef logic [StatsWidth-1:0]               stat_cnt_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Requester-side and write-port signals of the arbiter.
// REGFILE_WPORT_ARBITER_STATS_EN adds the two statistics counters.
interface regfile_wport_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned AW         = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            i_valid;
  logic [NUM_REQ*AW-1:0]         i_waddr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
  logic [NUM_REQ-1:0]            o_ready;
  logic                          o_wen;
  logic [AW-1:0]                 o_waddr;
  logic [DATA_WIDTH-1:0]         o_wdata;
`ifdef REGFILE_WPORT_ARBITER_STATS_EN
  logic [regfile_wport_arbiter_pkg::StatsWidth-1:0] o_conflict_cnt;
  logic [regfile_wport_arbiter_pkg::StatsWidth-1:0] o_aged_cnt;

  modport master (output i_valid, i_waddr, i_wdata,
                  input  o_ready, o_wen, o_waddr, o_wdata, o_conflict_cnt, o_aged_cnt);
  modport slave  (input  i_valid, i_waddr, i_wdata,
                  output o_ready, o_wen, o_waddr, o_wdata, o_conflict_cnt, o_aged_cnt);
`else
  modport master (output i_valid, i_waddr, i_wdata,
                  input  o_ready, o_wen, o_waddr, o_wdata);
  modport slave  (input  i_valid, i_waddr, i_wdata,
                  output o_ready, o_wen, o_waddr, o_wdata);
`endif
endinterface

// File: rtl/regfile_wport_arbiter_age.sv
// Per-requester saturating stall counter; flags when the requester has waited MAX_WAIT cycles.
module regfile_wport_arbiter_age
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic granted_i,
  output logic aged_o
);

  localparam age_t AgeMax = age_t'(MAX_WAIT);

  age_t age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (!valid_i || granted_i) begin
      age_d = '0;
    end else if (age_q != AgeMax) begin
      age_d = age_q + age_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  assign aged_o = (age_q == AgeMax);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Fixed-priority write-port arbiter with aging override and a one-cycle registered write stage.
// REGFILE_WPORT_ARBITER_STATS_EN adds conflict and aged-grant counters.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_FILE_SIZE = 32,
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned MAX_WAIT      = 4
) (
  input logic                     clk,
  input logic                     rst,
  regfile_wport_arbiter_if.slave  bus
);

  localparam int unsigned AW = addr_width(REG_FILE_SIZE);

  logic [NUM_REQ-1:0]    aged, prio_grant, aged_grant, grant;
  logic                  prio_found, aged_found, accept;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  logic                  wen_q, wen_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_age
    regfile_wport_arbiter_age #(
      .MAX_WAIT (MAX_WAIT)
    ) u_age (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (bus.i_valid[k]),
      .granted_i (grant[k]),
      .aged_o    (aged[k])
    );
  end

  always_comb begin
    prio_grant = '0;
    aged_grant = '0;
    prio_found = 1'b0;
    aged_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (bus.i_valid[k] && !prio_found) begin
        prio_grant[k] = 1'b1;
        prio_found    = 1'b1;
      end
      if (bus.i_valid[k] && aged[k] && !aged_found) begin
        aged_grant[k] = 1'b1;
        aged_found    = 1'b1;
      end
    end
    grant = rst ? '0 : (aged_found ? aged_grant : prio_grant);
  end

  // Grant is one-hot, so OR-ing the masked lanes is a clean mux.
  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        acc_addr = acc_addr | bus.i_waddr[k*AW +: AW];
        acc_data = acc_data | bus.i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    accept = |grant;
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (accept) begin
      wen_d   = (acc_addr != '0);
      waddr_d = acc_addr;
      wdata_d = acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs are masked by rst so a pending write cannot strobe during reset.
  assign bus.o_ready = grant;
  assign bus.o_wen   = wen_q & ~rst;
  assign bus.o_waddr = rst ? '0 : waddr_q;
  assign bus.o_wdata = rst ? '0 : wdata_q;

`ifdef REGFILE_WPORT_ARBITER_STATS_EN
  stat_cnt_t conflict_q, conflict_d, aged_cnt_q, aged_cnt_d;

  always_comb begin
    conflict_d = conflict_q;
    aged_cnt_d = aged_cnt_q;
    if ($countones(bus.i_valid) > 1) begin
      conflict_d = conflict_q + stat_cnt_t'(1);
    end
    if (aged_found && (aged_grant != prio_grant)) begin
      aged_cnt_d = aged_cnt_q + stat_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
      aged_cnt_q <= '0;
    end else begin
      conflict_q <= conflict_d;
      aged_cnt_q <= aged_cnt_d;
    end
  end

  assign bus.o_conflict_cnt = conflict_q;
  assign bus.o_aged_cnt     = aged_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized and directed bench for regfile_wport_arbiter against a behavioural model.
module tb_regfile_wport_arbiter;
  import regfile_wport_arbiter_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned RFS = 32;
  localparam int unsigned NR  = 2;
  localparam int unsigned MW  = 4;
  localparam int unsigned AW  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.NUM_REQ(NR), .AW(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wport_arbiter #(
    .DATA_WIDTH    (DW),
    .REG_FILE_SIZE (RFS),
    .NUM_REQ       (NR),
    .MAX_WAIT      (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          vld [NR];
  logic [AW-1:0] adr [NR];
  logic [DW-1:0] dat [NR];

  always_comb begin
    bus.i_valid = '0;
    bus.i_waddr = '0;
    bus.i_wdata = '0;
    for (int k = 0; k < NR; k++) begin
      bus.i_valid[k]           = vld[k];
      bus.i_waddr[k*AW +: AW]  = adr[k];
      bus.i_wdata[k*DW +: DW]  = dat[k];
    end
  end

  // Regfile fed by the DUT write port; writes whenever o_wen is seen.
  logic [DW-1:0] rf_dut [RFS];
  always @(posedge clk) begin
    if (bus.o_wen) rf_dut[bus.o_waddr] <= bus.o_wdata;
  end

  // Reference model state.
  int            age [NR];
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] rf_mdl [RFS];
  int unsigned   m_conf, m_aged;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, drop accepted requests.
  task automatic cycle();
    int            g, p, nv;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    g  = -1;
    p  = -1;
    nv = 0;
    for (int k = 0; k < NR; k++) begin
      if (vld[k]) nv++;
      if (vld[k] && p < 0) p = k;
      if (vld[k] && age[k] == MW && g < 0) g = k;
    end
    if (g < 0) g = p;
    if (rst) g = -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    check_eq("ready", 64'(bus.o_ready), 64'(exp_ready));
    check_eq("wen",   64'(bus.o_wen),   64'(rst ? 1'b0 : m_wen));
    check_eq("waddr", 64'(bus.o_waddr), 64'(rst ? '0 : m_waddr));
    check_eq("wdata", 64'(bus.o_wdata), 64'(rst ? '0 : m_wdata));
`ifdef REGFILE_WPORT_ARBITER_STATS_EN
    check_eq("conflict_cnt", 64'(bus.o_conflict_cnt), 64'(m_conf));
    check_eq("aged_cnt",     64'(bus.o_aged_cnt),     64'(m_aged));
`endif

    if (!rst && m_wen) rf_mdl[m_waddr] = m_wdata;
    if (rst) begin
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_conf = 0; m_aged = 0;
    end else begin
      m_wen = 1'b0;
      if (g >= 0) begin
        m_wen   = (adr[g] != 0);
        m_waddr = adr[g];
        m_wdata = dat[g];
      end
      if (nv > 1) m_conf++;
      if (g >= 0 && g != p) m_aged++;
    end
    for (int k = 0; k < NR; k++) begin
      if (rst || !vld[k] || k == g) age[k] = 0;
      else if (age[k] < int'(MW)) age[k]++;
    end

    @(posedge clk);
    #1;
    if (g >= 0) vld[g] = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NR; k++) begin
      vld[k] = 1'b0; adr[k] = '0; dat[k] = '0; age[k] = 0;
    end
    for (int i = 0; i < RFS; i++) begin
      rf_dut[i] = '0; rf_mdl[i] = '0;
    end
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_conf = 0; m_aged = 0;
    drain(2);
    rst = 1'b0;

    // Single requester
    vld[0] = 1'b1; adr[0] = 5'd5; dat[0] = 32'hDEADBEEF;
    drain(3);
    check_eq("rf5", 64'(rf_dut[5]), 64'h0000_0000_DEAD_BEEF);

    // Two-way conflict
    vld[0] = 1'b1; adr[0] = 5'd3; dat[0] = 32'h11;
    vld[1] = 1'b1; adr[1] = 5'd4; dat[1] = 32'h22;
    drain(4);

    // Starvation: req0 re-presents every cycle, req1 holds
    vld[1] = 1'b1; adr[1] = 5'd6; dat[1] = 32'h66;
    for (int i = 0; i < 5; i++) begin
      if (!vld[0]) begin
        vld[0] = 1'b1; adr[0] = 5'(10 + i); dat[0] = 32'(i);
      end
      cycle();
    end
    check_eq("starve_granted", 64'(vld[1]), 64'(1'b0));
    drain(3);
    check_eq("rf6", 64'(rf_dut[6]), 64'h66);

    // x0 write
    vld[1] = 1'b1; adr[1] = 5'd0; dat[1] = 32'hFFFF;
    drain(3);
    check_eq("rf0", 64'(rf_dut[0]), 64'h0);

    // Reset right after an accept
    vld[0] = 1'b1; adr[0] = 5'd7; dat[0] = 32'h55;
    cycle();
    rst = 1'b1;
    vld[1] = 1'b1; adr[1] = 5'd12; dat[1] = 32'h77;
    drain(2);
    rst = 1'b0;
    drain(3);
    check_eq("rf7", 64'(rf_dut[7]), 64'h0);
    check_eq("rf12", 64'(rf_dut[12]), 64'h77);

    // Same destination from both requesters
    vld[0] = 1'b1; adr[0] = 5'd9; dat[0] = 32'hA;
    vld[1] = 1'b1; adr[1] = 5'd9; dat[1] = 32'hB;
    drain(4);
    check_eq("rf9", 64'(rf_dut[9]), 64'hB);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NR; k++) begin
        if (!vld[k] && $urandom_range(0, 99) < 65) begin
          vld[k] = 1'b1;
          adr[k] = AW'($urandom_range(0, RFS - 1));
          dat[k] = $urandom;
        end
      end
      cycle();
    end
    rst = 1'b0;
    drain(8);
    for (int i = 0; i < RFS; i++) check_eq($sformatf("rf_final[%0d]", i), 64'(rf_dut[i]),
                                           64'(rf_mdl[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
